seg_s2p_rx: RTL and testbench

Serial-to-parallel receiver for the 7-segment shift-register link driven by the display transmitter (SEGCLK/SEGDT/SEGCLR/SEGEN, 64-bit frame, MSB first, one SEGCLK rising edge per bit). It oversamples the link in its own clock domain, reassembles complete frames into a 64-bit word and flags malformed frames. It sits on the board-emulation/loopback side: feeding the transmitter's pins back in lets the game's display contents be checked and mirrored (e.g. onto VGA or LEDs).

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_sync_edge.sv | 60 ++++++
 rtl/seg_s2p_rx.sv | 175 +++++++++++++++++
 tb/tb_seg_s2p_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment shift-register link receiver.
//   SEG_FRAME_BITS : bits per link frame (one display refresh word)
//   rx_state_e     : receiver FSM state (IDLE = waiting for first bit,
//                    SHIFT = frame partially received)
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int SEG_FRAME_BITS = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage : seg_pkg

// File: rtl/seg_sync_edge.sv
// -----------------------------------------------------------------------------
// seg_sync_edge
// Brings the four link pins into the receiver clock domain and detects rising
// edges of the link bit clock.
//   clk, rst_n      : receiver clock, asynchronous active-low reset
//   i_seg_clk       : link bit clock pin
//   i_seg_dt        : link serial data pin
//   i_seg_clr       : link clear pin (active-low)
//   i_seg_en        : link enable pin (active-high)
//   o_edge          : one-cycle pulse on a synchronized seg_clk rising edge
//   o_dt_s          : synchronized data, aligned with o_edge
//   o_clr_n_s       : synchronized clear (active-low)
//   o_en_s          : synchronized enable
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module seg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_seg_clk,
  input  logic i_seg_dt,
  input  logic i_seg_clr,
  input  logic i_seg_en,
  output logic o_edge,
  output logic o_dt_s,
  output logic o_clr_n_s,
  output logic o_en_s
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dt_sync;
  logic [SYNC_STAGES-1:0] r_clr_sync;
  logic [SYNC_STAGES-1:0] r_en_sync;
  logic                   r_clk_d;

  // Data uses the same depth as the bit clock so that the bit presented on
  // o_dt_s is the one that was on the pin when seg_clk rose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '0;
      r_dt_sync  <= '0;
      r_clr_sync <= '0;
      r_en_sync  <= '0;
      r_clk_d    <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_seg_clk};
      r_dt_sync  <= {r_dt_sync[SYNC_STAGES-2:0],  i_seg_dt};
      r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], i_seg_clr};
      r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0],  i_seg_en};
      r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
  assign o_dt_s    = r_dt_sync[SYNC_STAGES-1];
  assign o_clr_n_s = r_clr_sync[SYNC_STAGES-1];
  assign o_en_s    = r_en_sync[SYNC_STAGES-1];

endmodule : seg_sync_edge

// File: rtl/seg_s2p_rx.sv
// -----------------------------------------------------------------------------
// seg_s2p_rx
// Serial-to-parallel receiver for the 7-segment shift-register link
// (SEGCLK/SEGDT/SEGCLR/SEGEN). Oversamples the link, reassembles MSB-first
// frames of FRAME_BITS bits and reports each complete frame on num.
//   clk, rst_n   : receiver clock (>= 4x seg_clk), async active-low reset
//   seg_clk      : link bit clock, data sampled on its rising edge
//   seg_dt       : link serial data, MSB first
//   seg_clr      : link clear, active-low, discards a partial frame
//   seg_en       : link enable, bit-clock edges ignored while low
//   num          : last complete frame, bit FRAME_BITS-1 = first bit received
//   num_valid    : one-cycle pulse when num is updated
//   frame_err    : one-cycle pulse when a partial frame is dropped on timeout
//   busy         : high while a frame is partially received
//   o_dbg_state  : current receiver FSM state
// Build option: define SEG_S2P_TIMEOUT_EN to enable the idle-timeout that
// drops partial frames after IDLE_CYCLES clocks without a bit. Without it a
// partial frame waits until seg_clr or reset, and frame_err is tied low.
//
// Output handshake: num_valid is a strobe with no ready/back-pressure; num is
// updated in the same cycle num_valid is high and then holds until the next
// complete frame, so a consumer may sample num on the strobe or any time later.
// -----------------------------------------------------------------------------
module seg_s2p_rx
  import seg_pkg::*;
#(
  parameter int FRAME_BITS  = SEG_FRAME_BITS,
  parameter int IDLE_CYCLES = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_clk,
  input  logic                  seg_dt,
  input  logic                  seg_clr,
  input  logic                  seg_en,
  output logic [FRAME_BITS-1:0] num,
  output logic                  num_valid,
  output logic                  frame_err,
  output logic                  busy,
  output rx_state_e             o_dbg_state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic w_edge_raw;
  logic w_edge;
  logic w_dt_s;
  logic w_clr_n_s;
  logic w_en_s;

  seg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_seg_clk (seg_clk),
    .i_seg_dt  (seg_dt),
    .i_seg_clr (seg_clr),
    .i_seg_en  (seg_en),
    .o_edge    (w_edge_raw),
    .o_dt_s    (w_dt_s),
    .o_clr_n_s (w_clr_n_s),
    .o_en_s    (w_en_s)
  );

  assign w_edge = w_edge_raw & w_en_s;

  rx_state_e             r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  // The last bit of a frame goes straight into num, so only FRAME_BITS-1
  // earlier bits ever need holding.
  logic [FRAME_BITS-2:0] r_shreg;
  logic [FRAME_BITS-1:0] r_num;
  logic                  r_num_valid;

`ifdef SEG_S2P_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_frame_err;
  logic              w_timeout;

  assign w_timeout = (r_idle_cnt == IDLE_MAX);
`else
  // IDLE_CYCLES has no effect without the timeout; it is kept so both
  // builds share one parameter list.
  if (IDLE_CYCLES < 1) begin : g_idle_cycles_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_num       <= '0;
      r_num_valid <= 1'b0;
`ifdef SEG_S2P_TIMEOUT_EN
      r_idle_cnt  <= '0;
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_num_valid <= 1'b0;
`ifdef SEG_S2P_TIMEOUT_EN
      r_frame_err <= 1'b0;
`endif
      // Link clear wins over a bit edge in the same cycle; num is kept.
      if (!w_clr_n_s) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
`ifdef SEG_S2P_TIMEOUT_EN
        r_idle_cnt <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (w_edge) begin
              r_shreg   <= {r_shreg[FRAME_BITS-3:0], w_dt_s};
              r_bit_cnt <= ONE_CNT;
              r_state   <= SHIFT;
`ifdef SEG_S2P_TIMEOUT_EN
              r_idle_cnt <= '0;
`endif
            end
          end
          SHIFT: begin
            if (w_edge) begin
              r_shreg <= {r_shreg[FRAME_BITS-3:0], w_dt_s};
`ifdef SEG_S2P_TIMEOUT_EN
              r_idle_cnt <= '0;
`endif
              if (r_bit_cnt == LAST_CNT) begin
                r_num       <= {r_shreg, w_dt_s};
                r_num_valid <= 1'b1;
                r_bit_cnt   <= '0;
                r_state     <= IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + ONE_CNT;
              end
            end
`ifdef SEG_S2P_TIMEOUT_EN
            else if (w_timeout) begin
              // Leaving SHIFT clears the counter, so it never passes IDLE_MAX.
              r_frame_err <= 1'b1;
              r_bit_cnt   <= '0;
              r_idle_cnt  <= '0;
              r_state     <= IDLE;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
`endif
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign num         = r_num;
  assign num_valid   = r_num_valid;
  assign busy        = (r_state == SHIFT);
  assign o_dbg_state = r_state;
`ifdef SEG_S2P_TIMEOUT_EN
  assign frame_err   = r_frame_err;
`else
  assign frame_err   = 1'b0;
`endif

endmodule : seg_s2p_rx

// File: tb/tb_seg_s2p_rx.sv
// -----------------------------------------------------------------------------
// tb_seg_s2p_rx
// Bench for seg_s2p_rx. The link driver toggles the pins from the receiver
// clock's falling edge; a reference model collects every bit that is clocked
// in while enabled and not cleared, and packs each run of 64 into an expected
// frame (first bit = MSB). A monitor compares every num_valid strobe against
// the expected queue.
// -----------------------------------------------------------------------------
module tb_seg_s2p_rx;

  localparam int FB   = 64;
  localparam int IDLE = 256;
  localparam int SS   = 2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic seg_clk = 1'b0;
  logic seg_dt  = 1'b0;
  logic seg_clr = 1'b1;
  logic seg_en  = 1'b1;

  logic [FB-1:0] num;
  logic          num_valid;
  logic          frame_err;
  logic          busy;
  logic          dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seg_s2p_rx #(
    .FRAME_BITS  (FB),
    .IDLE_CYCLES (IDLE),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_clk     (seg_clk),
    .seg_dt      (seg_dt),
    .seg_clr     (seg_clr),
    .seg_en      (seg_en),
    .num         (num),
    .num_valid   (num_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [FB-1:0] exp_q[$];
  bit            m_q[$];
  logic [FB-1:0] last_num = '0;
  int            n_valid  = 0;
  int            n_err    = 0;
  int            t_rise   = 0;
  int            t_err    = 0;

  // Reference model: a frame is simply the next 64 accepted bits.
  task automatic model_bit(input bit b);
    logic [FB-1:0] w;
    if (seg_en && seg_clr) begin
      m_q.push_back(b);
      if (m_q.size() == FB) begin
        for (int i = 0; i < FB; i++) w[FB-1-i] = m_q[i];
        exp_q.push_back(w);
        last_num = w;
        m_q.delete();
      end
    end
  endtask

  task automatic model_flush();
    m_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic [FB-1:0] e;
    if (rst_n) begin
      if (num_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("num", num, e);
        end
      end
      if (frame_err) begin
        n_err++;
        t_err = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input bit b, input int half);
    seg_dt = b;
    repeat (half) @(negedge clk);
    seg_clk = 1'b1;
    t_rise  = cyc;
    model_bit(b);
    repeat (half) @(negedge clk);
    seg_clk = 1'b0;
  endtask

  // Sends the top nbits of w, MSB first.
  task automatic send_word(input logic [FB-1:0] w, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) send_bit(w[FB-1-i], half);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    seg_clr = 1'b0;
    model_flush();
    repeat (5) @(negedge clk);
    seg_clr = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Ends a dangling partial frame: by timeout when built in, else by clear.
  task automatic resolve_partial(input string tag);
    int e0;
    e0 = n_err;
`ifdef SEG_S2P_TIMEOUT_EN
    repeat (IDLE + 40) @(negedge clk);
    check({tag, "_err_cnt"}, n_err - e0, 1);
    model_flush();
`else
    repeat (IDLE + 40) @(negedge clk);
    check({tag, "_busy_wait"}, busy, 1);
    check({tag, "_err_cnt"}, n_err - e0, 0);
    pulse_clr();
`endif
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int v0;
    int e0;
    logic [FB-1:0] w;

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_num", num, 0);
    check("rst_num_valid", num_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame at clk/8
    send_word(64'h0123_4567_89AB_CDEF, FB, 4);
    drain("t1_drain");
    check("t1_num", num, 64'h0123_4567_89AB_CDEF);
    check("t1_busy", busy, 0);
    check("t1_valid_cnt", n_valid, 1);

    // back-to-back frames, no gap
    v0 = n_valid;
    send_word(64'hFFFF_0000_FFFF_0000, FB, 4);
    send_word(64'h0000_0000_0000_0001, FB, 4);
    drain("t2_drain");
    check("t2_valid_cnt", n_valid - v0, 2);
    check("t2_num", num, 64'h1);

    // 40 bits then silence
    e0 = n_err;
    send_word(64'hDEAD_BEEF_CAFE_F00D, 40, 4);
    check("t3_busy_mid", busy, 1);
`ifdef SEG_S2P_TIMEOUT_EN
    repeat (IDLE + 40) @(negedge clk);
    check("t3_err_cnt", n_err - e0, 1);
    // bit lands in shreg SS+1 clocks after the pin edge; error IDLE+1 later
    check("t3_err_delay", t_err - t_rise, IDLE + 1 + SS + 1);
    model_flush();
`else
    repeat (IDLE + 40) @(negedge clk);
    check("t3_err_cnt", n_err - e0, 0);
    check("t3_busy_hold", busy, 1);
    pulse_clr();
`endif
    check("t3_num_kept", num, last_num);
    check("t3_busy", busy, 0);

    // clear after 10 bits, then a full frame
    e0 = n_err;
    send_word(64'h1234_5678_9ABC_DEF0, 10, 4);
    pulse_clr();
    check("t4_busy_clr", busy, 0);
    send_word(64'hA5A5_A5A5_5A5A_5A5A, FB, 4);
    drain("t4_drain");
    check("t4_num", num, 64'hA5A5_A5A5_5A5A_5A5A);
    check("t4_err_cnt", n_err - e0, 0);

    // link disabled: edges must be ignored
    v0 = n_valid;
    seg_en = 1'b0;
    repeat (4) @(negedge clk);
    send_word({$urandom, $urandom}, FB, 3);
    repeat (4) @(negedge clk);
    check("t5_busy", busy, 0);
    seg_en = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_valid_cnt", n_valid - v0, 0);
    check("t5_num_kept", num, last_num);

    // reset mid-frame
    w = 64'h0F1E_2D3C_4B5A_6978;
    send_word(w, 20, 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_num", num, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", num_valid, 0);
    model_flush();
    exp_q.delete();
    last_num = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 20; i < FB; i++) send_bit(w[FB-1-i], 4);
    resolve_partial("t6");
    check("t6_num_after", num, 0);
    send_word(64'h8000_0000_0000_0001, FB, 4);
    drain("t6_drain");
    check("t6_num", num, 64'h8000_0000_0000_0001);

    // randomized frames, random bit-clock rate, random gaps
    for (int f = 0; f < 20; f++) begin
      send_word({$urandom, $urandom}, FB, $urandom_range(2, 5));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    drain("t7_drain");
    check("t7_num_last", num, last_num);
    check("t7_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg_s2p_rx
